reg_file_ld: RTL and testbench
==============================

Name: reg_file_ld

Overview:
- Parametrised register file for the downsampling datapath core. Generalises width, depth and memory-data width.
- Adds a selectable load destination with a split-transaction memory-load handshake (one outstanding load, with a scoreboard stall).
- Adds a synchronous per-register clear, a post-increment port for address/pointer registers, and optional write-to-read bypass.
- Dedicated outputs drive data-memory address and write data.

Parameters:
- DATA_W, 19, register width in bits
- NREGS, 16, number of registers (2..2**SEL_W)
- SEL_W, 4, width of every register-select bus
- MEM_W, 8, data-memory word width (MEM_W <= DATA_W)
- ADDR_REG, 0, index of register driving dm_addr
- WDATA_REG, 1, index of register driving dm_data
- BYPASS, 1, 1 = forward same-cycle C-bus write to A/B outputs; 0 = registered read only

Ports:
- clk  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- CLR  in  1  synchronous clear of register CLR_SEL
- CLR_SEL  in  SEL_W  clear target
- C_EN  in  1  C-bus write enable
- C_SEL  in  SEL_W  C-bus write target
- c_in  in  DATA_W  C-bus write data
- INC_EN  in  1  post-increment enable
- INC_SEL  in  SEL_W  increment target
- A_SEL  in  SEL_W  A-bus read select
- B_SEL  in  SEL_W  B-bus read select
- MEM_READ  in  1  load request, 1-cycle pulse
- LD_SEL  in  SEL_W  load destination register
- mem_valid  in  1  load data valid, 1-cycle pulse
- mem_data  in  MEM_W  load data
- a_out  out  DATA_W  A-bus data
- b_out  out  DATA_W  B-bus data
- dm_addr  out  DATA_W  regs[ADDR_REG]
- dm_data  out  MEM_W  regs[WDATA_REG][MEM_W-1:0]
- ld_busy  out  1  load outstanding
- stall  out  1  A_SEL or B_SEL targets the pending load destination

Behaviour:
- Reset (RST_N low, async):
  - all registers 0; FSM to IDLE; ld_dst 0.
  - Outputs: a_out=b_out=dm_addr=dm_data=0, ld_busy=0, stall=0.
  - Reset mid-load abandons the load; a mem_valid arriving after reset is ignored in IDLE.
- Load FSM, two states:
  - IDLE: MEM_READ=1 with LD_SEL<NREGS -> latch ld_dst=LD_SEL, go to WAIT. MEM_READ with LD_SEL>=NREGS is ignored.
  - WAIT: ld_busy=1. On mem_valid=1, write regs[ld_dst] <= zero-extended mem_data and go to IDLE the same edge.
  - MEM_READ in WAIT is dropped with no effect; the requester must honour ld_busy.
  - mem_valid in IDLE is ignored.
  - Latency: the loaded value is visible on a_out/b_out the cycle after the mem_valid edge. No bypass of mem_data.
- Stall: combinational. stall = ld_busy & ((A_SEL==ld_dst) | (B_SEL==ld_dst)).
- Write priority per register at each edge, highest first:
  1. CLR
  2. load writeback
  3. C-bus write
  4. increment
  - Only the highest-priority source writes a given register.
  - Operations targeting different registers all occur in the same cycle.
- Increment: regs[INC_SEL] <= regs[INC_SEL] + 1, modulo 2**DATA_W. 2**DATA_W-1 wraps to 0; no carry out.
- Out-of-range selects (>= NREGS): writes/clears/increments ignored; reads return 0.
- Reads: combinational from the array.
  - BYPASS=1: if C_EN & C_SEL==A_SEL (in range), a_out = c_in; same rule for B. The bypass is suppressed when CLR or a load writeback targets the same register in that cycle; the output then shows the pre-edge register value.
  - BYPASS=0: outputs show pre-edge values.
- dm_addr and dm_data are always registered values; they are never bypassed.

Test Plan:
- Reset: write 0x7FFFF to regs 0..15, pulse RST_N low mid-cycle -> all outputs 0 immediately, ld_busy=0.
- Load handshake: MEM_READ, LD_SEL=5, with A_SEL=5 -> ld_busy=1 and stall=1 next cycle. Three cycles later mem_valid with mem_data=0xA7 -> regs[5]=0x000A7 and ld_busy=0 after the edge. A second MEM_READ during WAIT is ignored.
- Priority collision: same edge CLR_SEL=3, C_SEL=3 with c_in=0x123, INC_SEL=3 -> regs[3]=0. Repeat without CLR -> 0x123.
- Increment wrap: regs[0]=0x7FFFF, INC_EN with INC_SEL=0 -> dm_addr=0. Concurrent C write to reg 2 lands in the same cycle.
- Bypass: BYPASS=1, C_EN with C_SEL=A_SEL=B_SEL=4, c_in=0x55 -> a_out=b_out=0x55 in the same cycle. With BYPASS=0 -> old value, then 0x55 next cycle.
- Out-of-range: NREGS=14, A_SEL=15 -> a_out=0; C_SEL=14 write leaves all registers unchanged.

Source files
------------

// File: rtl/reg_file_ld.sv
// Parametrised register file for the downsampling datapath core.
//
// Features:
//   - Combinational A/B read ports, with optional same-cycle C-bus forwarding.
//   - Three writers, plus a synchronous clear. Each register takes only the
//     highest-priority writer at each edge: CLR > load writeback > C-bus > increment.
//   - Split-transaction memory load. Only one load can be outstanding, and a
//     read of the pending destination raises stall.
//   - Dedicated data-memory address and write-data outputs.
//
// Ports:
//   clk, RST_N                       clock (rising edge), async active-low reset
//   CLR, CLR_SEL                     synchronous clear of one register
//   C_EN, C_SEL, c_in                C-bus write
//   INC_EN, INC_SEL                  post-increment (wraps modulo 2**DATA_W)
//   A_SEL, B_SEL -> a_out, b_out     read ports; out-of-range selects read 0
//   MEM_READ, LD_SEL                 load request and its destination register
//   mem_valid, mem_data              load response, zero-extended on writeback
//   dm_addr, dm_data                 regs[ADDR_REG], regs[WDATA_REG][MEM_W-1:0]
//   ld_busy, stall                   load outstanding / read hazard on load dest
module reg_file_ld #(
  parameter int unsigned DATA_W    = 19,
  parameter int unsigned NREGS     = 16,
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned MEM_W     = 8,
  parameter int unsigned ADDR_REG  = 0,
  parameter int unsigned WDATA_REG = 1,
  parameter int unsigned BYPASS    = 1
) (
  input  logic              clk,
  input  logic              RST_N,
  input  logic              CLR,
  input  logic [SEL_W-1:0]  CLR_SEL,
  input  logic              C_EN,
  input  logic [SEL_W-1:0]  C_SEL,
  input  logic [DATA_W-1:0] c_in,
  input  logic              INC_EN,
  input  logic [SEL_W-1:0]  INC_SEL,
  input  logic [SEL_W-1:0]  A_SEL,
  input  logic [SEL_W-1:0]  B_SEL,
  input  logic              MEM_READ,
  input  logic [SEL_W-1:0]  LD_SEL,
  input  logic              mem_valid,
  input  logic [MEM_W-1:0]  mem_data,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [DATA_W-1:0] dm_addr,
  output logic [MEM_W-1:0]  dm_data,
  output logic              ld_busy,
  output logic              stall
);

  localparam int unsigned NSEL = 2 ** SEL_W;

  typedef enum logic [0:0] {StIdle, StWait} ld_state_e;

  ld_state_e         state_q, state_d;
  logic [SEL_W-1:0]  ld_dst_q, ld_dst_d;
  logic              ld_wb;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Read view padded to the full select space. Slots past NREGS read as 0 and
  // are flagged invalid, so no select ever indexes beyond the storage.
  logic [DATA_W-1:0] rd_arr [NSEL];
  logic [NSEL-1:0]   sel_valid;

  for (genvar g = 0; g < NSEL; g++) begin : g_rd
    if (g < NREGS) begin : g_live
      assign rd_arr[g]    = regs_q[g];
      assign sel_valid[g] = 1'b1;
    end else begin : g_dead
      assign rd_arr[g]    = '0;
      assign sel_valid[g] = 1'b0;
    end
  end

  // Load FSM: next state and writeback strobe.
  always_comb begin
    state_d  = state_q;
    ld_dst_d = ld_dst_q;
    ld_wb    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MEM_READ && sel_valid[LD_SEL]) begin
          ld_dst_d = LD_SEL;
          state_d  = StWait;
        end
      end
      StWait: begin
        // A new MEM_READ here is dropped; only mem_valid matters.
        if (mem_valid) begin
          ld_wb   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ld_busy = (state_q == StWait);
  assign stall   = ld_busy && ((A_SEL == ld_dst_q) || (B_SEL == ld_dst_q));

  // Per-register next state. Later assignments override earlier ones, so the
  // statements are ordered from lowest priority to highest. Out-of-range
  // selects never match any index.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (INC_EN && (INC_SEL == SEL_W'(i))) regs_d[i] = regs_q[i] + DATA_W'(1);
      if (C_EN && (C_SEL == SEL_W'(i)))     regs_d[i] = c_in;
      if (ld_wb && (ld_dst_q == SEL_W'(i))) regs_d[i] = DATA_W'(mem_data);
      if (CLR && (CLR_SEL == SEL_W'(i)))    regs_d[i] = '0;
    end
  end

  // Forward c_in only when the C-bus write will actually land. If a clear or a
  // load writeback takes the register, the port shows the pre-edge value.
  logic c_blocked;
  logic c_fwd;

  always_comb begin
    c_blocked = (CLR && (CLR_SEL == C_SEL)) || (ld_wb && (ld_dst_q == C_SEL));
    c_fwd     = (BYPASS != 0) && C_EN && sel_valid[C_SEL] && !c_blocked;
    a_out     = (c_fwd && (A_SEL == C_SEL)) ? c_in : rd_arr[A_SEL];
    b_out     = (c_fwd && (B_SEL == C_SEL)) ? c_in : rd_arr[B_SEL];
  end

  assign dm_addr = regs_q[ADDR_REG];
  assign dm_data = regs_q[WDATA_REG][MEM_W-1:0];

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      ld_dst_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ld_dst_q <= ld_dst_d;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_reg_file_ld.sv
// Self-checking bench for reg_file_ld.
//
// Two instances share the same stimulus:
//   u_dut0  default parameters (16 registers, bypass on)
//   u_dut1  NREGS=14, BYPASS=0
//
// The main sequence is a vector table for u_dut0. Expected outputs are queued
// when a vector is driven and popped when the outputs are sampled.
module tb_reg_file_ld;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, c_en, inc_en, mem_read, mem_valid;
  logic [3:0]  clr_sel, c_sel, inc_sel, a_sel, b_sel, ld_sel;
  logic [18:0] c_in;
  logic [7:0]  mem_data;

  logic [18:0] a0, b0, addr0, a1, b1, addr1;
  logic [7:0]  data0, data1;
  logic        busy0, stall0, busy1, stall1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_ld u_dut0 (
    .clk(clk), .RST_N(rst_n), .CLR(clr), .CLR_SEL(clr_sel), .C_EN(c_en), .C_SEL(c_sel),
    .c_in(c_in), .INC_EN(inc_en), .INC_SEL(inc_sel), .A_SEL(a_sel), .B_SEL(b_sel),
    .MEM_READ(mem_read), .LD_SEL(ld_sel), .mem_valid(mem_valid), .mem_data(mem_data),
    .a_out(a0), .b_out(b0), .dm_addr(addr0), .dm_data(data0), .ld_busy(busy0), .stall(stall0)
  );

  reg_file_ld #(.NREGS(14), .BYPASS(0)) u_dut1 (
    .clk(clk), .RST_N(rst_n), .CLR(clr), .CLR_SEL(clr_sel), .C_EN(c_en), .C_SEL(c_sel),
    .c_in(c_in), .INC_EN(inc_en), .INC_SEL(inc_sel), .A_SEL(a_sel), .B_SEL(b_sel),
    .MEM_READ(mem_read), .LD_SEL(ld_sel), .mem_valid(mem_valid), .mem_data(mem_data),
    .a_out(a1), .b_out(b1), .dm_addr(addr1), .dm_data(data1), .ld_busy(busy1), .stall(stall1)
  );

  typedef struct {
    string       name;
    logic [3:0]  a_sel, b_sel;
    logic        c_en;
    logic [3:0]  c_sel;
    logic [18:0] c_in;
    logic        inc_en;
    logic [3:0]  inc_sel;
    logic        clr;
    logic [3:0]  clr_sel;
    logic        mem_read;
    logic [3:0]  ld_sel;
    logic        mem_valid;
    logic [7:0]  mem_data;
    logic [18:0] ea, eb, eaddr;
    logic [7:0]  edata;
    logic        ebusy, estall;
  } vec_t;

  typedef struct {
    string       name;
    logic [18:0] ea, eb, eaddr;
    logic [7:0]  edata;
    logic        ebusy, estall;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(string name, logic [3:0] as, logic [3:0] bs,
                              logic ce, logic [3:0] cs, logic [18:0] ci,
                              logic ie, logic [3:0] is, logic cl, logic [3:0] cls,
                              logic mr, logic [3:0] ls, logic mv, logic [7:0] md,
                              logic [18:0] ea, logic [18:0] eb, logic [18:0] ead,
                              logic [7:0] ed, logic eby, logic est);
    vec_t v;
    v.name = name; v.a_sel = as; v.b_sel = bs; v.c_en = ce; v.c_sel = cs; v.c_in = ci;
    v.inc_en = ie; v.inc_sel = is; v.clr = cl; v.clr_sel = cls; v.mem_read = mr;
    v.ld_sel = ls; v.mem_valid = mv; v.mem_data = md; v.ea = ea; v.eb = eb;
    v.eaddr = ead; v.edata = ed; v.ebusy = eby; v.estall = est;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    clr = 0; clr_sel = 0; c_en = 0; c_sel = 0; c_in = 0; inc_en = 0; inc_sel = 0;
    a_sel = 0; b_sel = 0; mem_read = 0; ld_sel = 0; mem_valid = 0; mem_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    chk("rst_a0", {13'b0, a0}, 0);
    chk("rst_busy0", {31'b0, busy0}, 0);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    a_sel = v.a_sel; b_sel = v.b_sel; c_en = v.c_en; c_sel = v.c_sel; c_in = v.c_in;
    inc_en = v.inc_en; inc_sel = v.inc_sel; clr = v.clr; clr_sel = v.clr_sel;
    mem_read = v.mem_read; ld_sel = v.ld_sel; mem_valid = v.mem_valid; mem_data = v.mem_data;
    e.name = v.name; e.ea = v.ea; e.eb = v.eb; e.eaddr = v.eaddr; e.edata = v.edata;
    e.ebusy = v.ebusy; e.estall = v.estall;
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".a"}, {13'b0, a0}, {13'b0, e.ea});
    chk({e.name, ".b"}, {13'b0, b0}, {13'b0, e.eb});
    chk({e.name, ".addr"}, {13'b0, addr0}, {13'b0, e.eaddr});
    chk({e.name, ".data"}, {24'b0, data0}, {24'b0, e.edata});
    chk({e.name, ".busy"}, {31'b0, busy0}, {31'b0, e.ebusy});
    chk({e.name, ".stall"}, {31'b0, stall0}, {31'b0, e.estall});
  endtask

  initial begin
    // Columns: name, a, b | c_en c_sel c_in | inc | clr | mem_read ld_sel | mem_valid data
    //          | exp a, b, dm_addr, dm_data, ld_busy, stall
    tbl.push_back(mk("wr1", 1, 0, 1, 1, 19'h12345, 0, 0, 0, 0, 0, 0, 0, 0,
                     19'h12345, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk("wr0", 1, 2, 1, 0, 19'h7FFFF, 0, 0, 0, 0, 0, 0, 0, 0,
                     19'h12345, 0, 0, 8'h45, 0, 0));
    tbl.push_back(mk("incwrap", 0, 2, 1, 2, 19'h00ABC, 1, 0, 0, 0, 0, 0, 0, 0,
                     19'h7FFFF, 19'hABC, 19'h7FFFF, 8'h45, 0, 0));
    tbl.push_back(mk("postwrap", 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 19'hABC, 0, 8'h45, 0, 0));
    tbl.push_back(mk("prio_clr", 3, 3, 1, 3, 19'h123, 1, 3, 1, 3, 0, 0, 0, 0,
                     0, 0, 0, 8'h45, 0, 0));
    tbl.push_back(mk("prio_c", 3, 1, 1, 3, 19'h123, 1, 3, 0, 0, 0, 0, 0, 0,
                     19'h123, 19'h12345, 0, 8'h45, 0, 0));
    tbl.push_back(mk("inc3", 3, 3, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0,
                     19'h123, 19'h123, 0, 8'h45, 0, 0));
    tbl.push_back(mk("chk3", 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     19'h124, 19'h124, 0, 8'h45, 0, 0));
    tbl.push_back(mk("byp4", 4, 4, 1, 4, 19'h55, 0, 0, 0, 0, 0, 0, 0, 0,
                     19'h55, 19'h55, 0, 8'h45, 0, 0));
    tbl.push_back(mk("ld_req", 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0,
                     0, 0, 0, 8'h45, 0, 0));
    tbl.push_back(mk("wait1", 5, 4, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0,
                     0, 19'h55, 0, 8'h45, 1, 1));
    tbl.push_back(mk("wait2", 6, 4, 1, 5, 19'h1FFFF, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 19'h55, 0, 8'h45, 1, 0));
    tbl.push_back(mk("wb", 5, 5, 1, 5, 19'h333, 0, 0, 0, 0, 0, 0, 1, 8'hA7,
                     19'h1FFFF, 19'h1FFFF, 0, 8'h45, 1, 1));
    tbl.push_back(mk("postwb", 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     19'hA7, 0, 0, 8'h45, 0, 0));
    tbl.push_back(mk("stray", 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'hFF,
                     19'hA7, 0, 0, 8'h45, 0, 0));
    tbl.push_back(mk("chk_stray", 6, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 19'hA7, 0, 8'h45, 0, 0));
    tbl.push_back(mk("clr1", 1, 2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,
                     19'h12345, 19'hABC, 0, 8'h45, 0, 0));
    tbl.push_back(mk("postclr", 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 19'hABC, 0, 8'h00, 0, 0));

    // Main table on u_dut0.
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      #2;
      compare_head();
      tick();
    end
    chk("sb_drained", sb.size(), 0);

    // Asynchronous reset mid-cycle, including while a load is outstanding.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      idle(); c_en = 1; c_sel = 4'(i); c_in = 19'h7FFFF;
      tick();
    end
    idle(); a_sel = 15; b_sel = 7;
    #2;
    chk("fill.a", {13'b0, a0}, 32'h7FFFF);
    chk("fill.b", {13'b0, b0}, 32'h7FFFF);
    chk("fill.addr", {13'b0, addr0}, 32'h7FFFF);
    chk("fill.data", {24'b0, data0}, 32'hFF);
    mem_read = 1; ld_sel = 5;
    tick();
    idle(); a_sel = 5; b_sel = 7;
    #2;
    chk("preRst.busy", {31'b0, busy0}, 1);
    chk("preRst.stall", {31'b0, stall0}, 1);
    rst_n = 1'b0;
    #1;
    chk("midRst.a", {13'b0, a0}, 0);
    chk("midRst.b", {13'b0, b0}, 0);
    chk("midRst.addr", {13'b0, addr0}, 0);
    chk("midRst.data", {24'b0, data0}, 0);
    chk("midRst.busy", {31'b0, busy0}, 0);
    chk("midRst.stall", {31'b0, stall0}, 0);
    rst_n = 1'b1;
    tick();
    mem_valid = 1; mem_data = 8'h11;
    #2;
    chk("postRst.busy", {31'b0, busy0}, 0);
    tick();
    idle(); a_sel = 5;
    #2;
    chk("postRst.r5", {13'b0, a0}, 0);
    tick();

    // Out-of-range selects and no-bypass read timing on u_dut1.
    do_reset();
    c_en = 1; c_sel = 4; c_in = 19'h55; a_sel = 4; b_sel = 4;
    #2;
    chk("nobyp.a1", {13'b0, a1}, 0);
    chk("nobyp.b1", {13'b0, b1}, 0);
    chk("byp.a0", {13'b0, a0}, 32'h55);
    tick();
    idle(); a_sel = 4; b_sel = 4;
    #2;
    chk("nobyp_next.a1", {13'b0, a1}, 32'h55);
    chk("nobyp_next.b1", {13'b0, b1}, 32'h55);
    tick();
    idle(); c_en = 1; c_sel = 14; c_in = 19'h999; inc_en = 1; inc_sel = 15;
    a_sel = 15; b_sel = 14;
    #2;
    chk("oor.a1", {13'b0, a1}, 0);
    chk("oor.b1", {13'b0, b1}, 0);
    chk("inr.b0", {13'b0, b0}, 32'h999);
    tick();
    idle();
    for (int s = 0; s < 14; s++) begin
      a_sel = 4'(s);
      #1;
      chk($sformatf("oor_keep.r%0d", s), {13'b0, a1}, (s == 4) ? 32'h55 : 32'h0);
    end
    a_sel = 14;
    #1;
    chk("oor.r14_dut1", {13'b0, a1}, 0);
    chk("inr.r14_dut0", {13'b0, a0}, 32'h999);
    a_sel = 15;
    #1;
    chk("oor.r15_dut1", {13'b0, a1}, 0);
    chk("inr.r15_dut0", {13'b0, a0}, 1);
    tick();
    idle(); mem_read = 1; ld_sel = 15; a_sel = 15;
    tick();
    idle(); a_sel = 15;
    #2;
    chk("oorLd.busy1", {31'b0, busy1}, 0);
    chk("oorLd.stall1", {31'b0, stall1}, 0);
    chk("inrLd.busy0", {31'b0, busy0}, 1);
    chk("inrLd.stall0", {31'b0, stall0}, 1);
    mem_valid = 1; mem_data = 8'h3C;
    tick();
    idle(); a_sel = 15;
    #2;
    chk("inrLd.r15", {13'b0, a0}, 32'h3C);
    chk("inrLd.done", {31'b0, busy0}, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
